video_fetcher: RTL and testbench

Wishbone bus master that fetches one scanline of playfield halfwords from video memory per request and stores them into the scanline line buffers. Sits directly upstream of the line buffers: its store port drives their halfword store address, store data and store write-enable, and the CRTC's odd/even line signal selects which buffer receives the data. Maintains the running video memory pointer across a frame: reloads it at vertical sync and advances it by one line per burst.

---
 rtl/video_fetcher.sv | 117 +++++++++++
 tb/tb_video_fetcher.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fetcher.sv
// video_fetcher: Wishbone master that bursts one scanline of halfwords from
// video memory into the line buffers. It keeps a running frame pointer that
// is reloaded at vertical sync and advances by LINE_WORDS on each burst.
module video_fetcher #(
  parameter int unsigned LINE_WORDS = 40
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        EN_I,
  input  logic        LINE_I,
  input  logic        VSYNC_I,
  input  logic [22:0] BASE_I,
  output logic [22:0] ADR_O,
  output logic        CYC_O,
  output logic        STB_O,
  input  logic        ACK_I,
  input  logic [15:0] DAT_I,
  output logic [5:0]  S_ADR_O,
  output logic [15:0] S_DAT_O,
  output logic        S_WE_O,
  output logic        BUSY_O,
  output logic        OVR_O
);

  localparam logic IDLE  = 1'b0;
  localparam logic FETCH = 1'b1;

  localparam logic [5:0] LAST = 6'(LINE_WORDS - 1);

  logic        state_q,  state_d;
  logic [22:0] ptr_q,    ptr_d;
  logic [5:0]  count_q,  count_d;
  logic        reload_q, reload_d;
  logic [5:0]  s_adr_q,  s_adr_d;
  logic [15:0] s_dat_q,  s_dat_d;
  logic        s_we_q,   s_we_d;
  logic        ovr_q,    ovr_d;

  // Next-state logic for the fetch sequencer, pointer and store port.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    reload_d = reload_q;
    s_adr_d  = s_adr_q;
    s_dat_d  = s_dat_q;
    s_we_d   = 1'b0;
    ovr_d    = 1'b0;

    if (state_q == IDLE) begin
      // A reload in the same cycle as a line request takes effect first,
      // so the burst begins at the new base.
      if (VSYNC_I) begin
        ptr_d = BASE_I;
      end
      if (LINE_I && EN_I) begin
        state_d = FETCH;
        count_d = '0;
      end
    end else begin
      if (VSYNC_I) begin
        reload_d = 1'b1;
      end
      if (LINE_I) begin
        ovr_d = 1'b1;
      end
      if (ACK_I) begin
        s_dat_d = DAT_I;
        s_adr_d = count_q;
        s_we_d  = 1'b1;
        count_d = count_q + 6'd1;
        if (count_q == LAST) begin
          // A reload requested during this burst (or on its final edge)
          // replaces the usual advance once the line is complete.
          state_d  = IDLE;
          reload_d = 1'b0;
          ptr_d    = (reload_q || VSYNC_I) ? BASE_I : ptr_q + 23'd1;
        end else begin
          ptr_d = ptr_q + 23'd1;
        end
      end
    end
  end

  // State registers; asynchronous reset clears every output immediately.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      count_q  <= '0;
      reload_q <= 1'b0;
      s_adr_q  <= '0;
      s_dat_q  <= '0;
      s_we_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      s_adr_q  <= s_adr_d;
      s_dat_q  <= s_dat_d;
      s_we_q   <= s_we_d;
      ovr_q    <= ovr_d;
    end
  end

  assign ADR_O   = ptr_q;
  assign CYC_O   = (state_q == FETCH);
  assign STB_O   = (state_q == FETCH);
  assign BUSY_O  = (state_q == FETCH);
  assign S_ADR_O = s_adr_q;
  assign S_DAT_O = s_dat_q;
  assign S_WE_O  = s_we_q;
  assign OVR_O   = ovr_q;

endmodule

// File: tb/tb_video_fetcher.sv
// Self-checking bench for video_fetcher with a 4-word line and a Wishbone
// slave model returning 0xA000 + address.
module tb_video_fetcher;

  localparam int unsigned LW = 4;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        EN_I;
  logic        LINE_I;
  logic        VSYNC_I;
  logic [22:0] BASE_I;
  logic [22:0] ADR_O;
  logic        CYC_O;
  logic        STB_O;
  logic        ACK_I = 1'b0;
  logic [15:0] DAT_I = '0;
  logic [5:0]  S_ADR_O;
  logic [15:0] S_DAT_O;
  logic        S_WE_O;
  logic        BUSY_O;
  logic        OVR_O;

  video_fetcher #(.LINE_WORDS(LW)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .EN_I(EN_I), .LINE_I(LINE_I),
    .VSYNC_I(VSYNC_I), .BASE_I(BASE_I), .ADR_O(ADR_O), .CYC_O(CYC_O),
    .STB_O(STB_O), .ACK_I(ACK_I), .DAT_I(DAT_I), .S_ADR_O(S_ADR_O),
    .S_DAT_O(S_DAT_O), .S_WE_O(S_WE_O), .BUSY_O(BUSY_O), .OVR_O(OVR_O)
  );

  always #5 CLK_I = ~CLK_I;

  int nvec = 0;
  int nerr = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [5:0]  sadr;
    logic [15:0] sdat;
  } store_t;

  logic [22:0] adr_q[$];
  store_t      st_q[$];
  logic [22:0] model_ptr;

  logic        force_ack = 1'b0;
  logic        wait_mode = 1'b0;
  int          wcnt = 0;
  int          ack_cnt = 0;
  int          st_cnt = 0;
  int          ovr_cnt = 0;
  logic        prev_wait = 1'b0;
  logic [22:0] prev_adr = '0;

  // Slave model and output monitor, both on the falling edge.
  always @(negedge CLK_I) begin
    if (S_WE_O) begin
      st_cnt++;
      if (st_q.size() == 0) begin
        check_eq("unexpected_store", {S_ADR_O, S_DAT_O}, '1);
      end else begin
        store_t e;
        e = st_q.pop_front();
        check_eq("store_adr", S_ADR_O, e.sadr);
        check_eq("store_dat", S_DAT_O, e.sdat);
      end
    end
    if (OVR_O) ovr_cnt++;
    if (prev_wait) begin
      check_eq("stb_held", {CYC_O, STB_O}, 2'b11);
      check_eq("adr_stable", ADR_O, prev_adr);
    end
    prev_wait = 1'b0;
    if (CYC_O && STB_O) begin
      wcnt++;
      ACK_I = !wait_mode || (wcnt % 3 == 0);
    end else begin
      wcnt = 0;
      ACK_I = force_ack;
    end
    DAT_I = 16'hA000 + ADR_O[15:0];
    if (CYC_O && STB_O) begin
      if (ACK_I) begin
        ack_cnt++;
        if (adr_q.size() == 0) check_eq("unexpected_ack_adr", ADR_O, '1);
        else check_eq("ack_adr", ADR_O, adr_q.pop_front());
      end else begin
        prev_wait = 1'b1;
        prev_adr  = ADR_O;
      end
    end
  end

  task automatic do_line(input logic accept);
    @(negedge CLK_I);
    LINE_I = 1'b1;
    if (accept) begin
      for (int unsigned i = 0; i < LW; i++) begin
        logic [22:0] a;
        store_t s;
        a = model_ptr + 23'(i);
        adr_q.push_back(a);
        s.sadr = 6'(i);
        s.sdat = 16'hA000 + a[15:0];
        st_q.push_back(s);
      end
      model_ptr = model_ptr + 23'(LW);
    end
    @(negedge CLK_I);
    LINE_I = 1'b0;
  endtask

  task automatic pulse_vsync(input logic [22:0] base);
    @(negedge CLK_I);
    BASE_I  = base;
    VSYNC_I = 1'b1;
    model_ptr = base;
    @(negedge CLK_I);
    VSYNC_I = 1'b0;
  endtask

  // Waits for the burst to finish (bounded), returns busy cycle count and
  // confirms every expected store and address was consumed.
  task automatic finish_burst(input string tag, output int n);
    int s0;
    s0 = st_cnt;
    n = 0;
    while (BUSY_O && n < 200) begin
      n++;
      @(negedge CLK_I);
    end
    check_eq({tag, "_timeout"}, (n < 200), 1'b1);
    @(negedge CLK_I);
    @(negedge CLK_I);
    check_eq({tag, "_adr_left"}, adr_q.size(), 0);
    check_eq({tag, "_st_left"}, st_q.size(), 0);
    check_eq({tag, "_busy_after"}, {CYC_O, STB_O, BUSY_O, S_WE_O}, 4'b0000);
  endtask

  initial begin
    int n, s0, o0, a0;
    RST_I = 1'b0; EN_I = 1'b1; LINE_I = 1'b0; VSYNC_I = 1'b0;
    BASE_I = '0; force_ack = 1'b1;
    model_ptr = '0;

    // Held in reset with ACK high and LINE toggling.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK_I);
      LINE_I = ~LINE_I;
      #1 check_eq("reset_outputs",
                  {ADR_O, CYC_O, STB_O, S_ADR_O, S_DAT_O, S_WE_O, BUSY_O, OVR_O}, '0);
    end
    @(negedge CLK_I);
    LINE_I = 1'b0; force_ack = 1'b0;
    RST_I = 1'b1;

    // First burst after reset starts at 0.
    s0 = st_cnt;
    do_line(1'b1);
    finish_burst("burst0", n);
    check_eq("burst0_len", n, LW);
    check_eq("burst0_stores", st_cnt - s0, LW);

    // Zero-wait bursts from a new base, then the following line.
    pulse_vsync(23'h000100);
    s0 = st_cnt;
    do_line(1'b1);
    finish_burst("zw1", n);
    check_eq("zw1_len", n, LW);
    check_eq("zw1_stores", st_cnt - s0, LW);
    do_line(1'b1);
    finish_burst("zw2", n);
    check_eq("zw2_len", n, LW);

    // Disabled line request: nothing happens.
    EN_I = 1'b0;
    o0 = ovr_cnt; s0 = st_cnt;
    do_line(1'b0);
    repeat (3) @(negedge CLK_I);
    check_eq("en0_idle", {BUSY_O, CYC_O}, 2'b00);
    check_eq("en0_no_ovr", ovr_cnt - o0, 0);
    check_eq("en0_no_store", st_cnt - s0, 0);
    EN_I = 1'b1;

    // Wait states: ACK every third cycle.
    wait_mode = 1'b1;
    s0 = st_cnt;
    do_line(1'b1);
    finish_burst("wait", n);
    check_eq("wait_stores", st_cnt - s0, LW);

    // VSYNC during the second word: burst completes, next line reloads.
    pulse_vsync(23'h000100);
    do_line(1'b1);
    a0 = ack_cnt;
    n = 0;
    while (ack_cnt - a0 < 1 && n < 50) begin
      n++;
      @(negedge CLK_I);
    end
    check_eq("vs_first_ack_timeout", (n < 50), 1'b1);
    BASE_I = 23'h000200; VSYNC_I = 1'b1;
    model_ptr = 23'h000200;
    @(negedge CLK_I);
    VSYNC_I = 1'b0;
    finish_burst("vs_mid", n);
    do_line(1'b1);
    finish_burst("vs_next", n);
    wait_mode = 1'b0;

    // Overrun: LINE during a burst gives one OVR pulse, no extra burst.
    o0 = ovr_cnt; s0 = st_cnt;
    do_line(1'b1);
    LINE_I = 1'b1;
    @(negedge CLK_I);
    LINE_I = 1'b0;
    finish_burst("ovr", n);
    repeat (3) @(negedge CLK_I);
    check_eq("ovr_pulses", ovr_cnt - o0, 1);
    check_eq("ovr_stores", st_cnt - s0, LW);
    check_eq("ovr_no_extra", BUSY_O, 1'b0);
    do_line(1'b1);
    finish_burst("ovr_next", n);

    // Asynchronous reset after two ACKs.
    do_line(1'b1);
    a0 = ack_cnt;
    n = 0;
    while (ack_cnt - a0 < 2 && n < 50) begin
      n++;
      @(negedge CLK_I);
    end
    check_eq("rst_mid_ack_timeout", (n < 50), 1'b1);
    @(posedge CLK_I);
    #2;
    check_eq("rst_mid_pre", {CYC_O, STB_O, S_WE_O}, 3'b111);
    RST_I = 1'b0;
    #1;
    check_eq("rst_mid_async", {CYC_O, STB_O, S_WE_O}, 3'b000);
    adr_q.delete();
    st_q.delete();
    @(negedge CLK_I);
    RST_I = 1'b1;
    model_ptr = '0;
    check_eq("rst_mid_ptr", ADR_O, 23'h0);
    check_eq("rst_mid_busy", BUSY_O, 1'b0);
    s0 = st_cnt;
    do_line(1'b1);
    finish_burst("post_rst", n);
    check_eq("post_rst_stores", st_cnt - s0, LW);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
